// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline-side signal bundle for the hazard controller.
// The pipeline drives the master side; the controller uses the slave side.
interface hazard_ctrl_mc_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned CNT_W      = 32
) ();

  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_addr;
  logic [REG_ADDR_W-1:0]         ex_rd_addr;
  logic                          ex_valid;
  logic                          ex_mem_read;
  logic                          ex_mc_op;
  logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs_addr;
  logic [NUM_SRC-1:0]            dec_rs_used;
  logic [REG_ADDR_W-1:0]         mem_reg_write_addr;
  logic                          mem_reg_write_signal;
  logic [REG_ADDR_W-1:0]         wb_reg_write_addr;
  logic                          wb_reg_write_signal;
  logic                          take_branch;
  logic                          mc_done;

  logic [2*NUM_SRC-1:0]          forward_sel;
  logic                          stall_fetch;
  logic                          stall_dec;
  logic                          stall_ex;
  logic                          flush_fetch_dec;
  logic                          flush_dec_ex;
  logic                          mc_start;
  logic                          mc_busy;
  logic [CNT_W-1:0]              perf_stall_cycles;
  logic [CNT_W-1:0]              perf_flush_count;

  modport master (
    output ex_rs_addr, ex_rd_addr, ex_valid, ex_mem_read, ex_mc_op,
    output dec_rs_addr, dec_rs_used,
    output mem_reg_write_addr, mem_reg_write_signal,
    output wb_reg_write_addr, wb_reg_write_signal,
    output take_branch, mc_done,
    input  forward_sel, stall_fetch, stall_dec, stall_ex,
    input  flush_fetch_dec, flush_dec_ex, mc_start, mc_busy,
    input  perf_stall_cycles, perf_flush_count
  );

  modport slave (
    input  ex_rs_addr, ex_rd_addr, ex_valid, ex_mem_read, ex_mc_op,
    input  dec_rs_addr, dec_rs_used,
    input  mem_reg_write_addr, mem_reg_write_signal,
    input  wb_reg_write_addr, wb_reg_write_signal,
    input  take_branch, mc_done,
    output forward_sel, stall_fetch, stall_dec, stall_ex,
    output flush_fetch_dec, flush_dec_ex, mc_start, mc_busy,
    output perf_stall_cycles, perf_flush_count
  );

endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller: operand forwarding, load-use stall, multicycle execute
// stall, multi-cycle branch flush and saturating stall/flush counters.
module hazard_ctrl_mc #(
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned NUM_SRC          = 2,
  parameter int unsigned MC_FIXED_LATENCY = 0,
  parameter int unsigned FLUSH_DEPTH      = 1,
  parameter int unsigned CNT_W            = 32
) (
  input logic             clk,
  input logic             rst,
  hazard_ctrl_mc_if.slave bus
);

  // One down-counter serves both the fixed-latency wait and the flush hold.
  localparam int unsigned CntMax = (MC_FIXED_LATENCY > FLUSH_DEPTH) ? MC_FIXED_LATENCY
                                                                     : FLUSH_DEPTH;
  localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StMcWait, StFlushHold} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, flush_cnt_q;

  logic [2*NUM_SRC-1:0]  fwd;
  logic [REG_ADDR_W-1:0] src, dsrc;
  logic                  load_use;
  logic                  mc_done_int;
  logic                  stall_all, stall_fd, flush_fd, flush_de, start, busy, flush_evt;

  always_comb begin
    fwd = '0;
    src = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = bus.ex_rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
      if (src != '0 && bus.mem_reg_write_signal && src == bus.mem_reg_write_addr) begin
        fwd[2*i +: 2] = 2'b11;
      end else if (src != '0 && bus.wb_reg_write_signal && src == bus.wb_reg_write_addr) begin
        fwd[2*i +: 2] = 2'b10;
      end
    end
  end

  always_comb begin
    load_use = 1'b0;
    dsrc     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      dsrc = bus.dec_rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
      if (bus.dec_rs_used[i] && dsrc == bus.ex_rd_addr) begin
        load_use = 1'b1;
      end
    end
    load_use = load_use && bus.ex_valid && bus.ex_mem_read && (bus.ex_rd_addr != '0);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_all   = 1'b0;
    stall_fd    = 1'b0;
    flush_fd    = 1'b0;
    flush_de    = 1'b0;
    start       = 1'b0;
    busy        = 1'b0;
    flush_evt   = 1'b0;
    mc_done_int = (MC_FIXED_LATENCY == 0) ? bus.mc_done : (cnt_q == CntW'(1));

    unique case (state_q)
      StIdle: begin
        if (bus.ex_valid && bus.ex_mc_op) begin
          start     = 1'b1;
          stall_all = 1'b1;
          cnt_d     = CntW'(MC_FIXED_LATENCY);
          state_d   = StMcWait;
        end else if (bus.take_branch) begin
          flush_fd  = 1'b1;
          flush_de  = 1'b1;
          flush_evt = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            cnt_d   = CntW'(FLUSH_DEPTH - 1);
            state_d = StFlushHold;
          end
        end else if (load_use) begin
          stall_fd = 1'b1;
          flush_de = 1'b1;
        end
      end
      StMcWait: begin
        busy = 1'b1;
        if (mc_done_int) begin
          state_d = StIdle;
        end else begin
          stall_all = 1'b1;
        end
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      end
      StFlushHold: begin
        flush_fd = 1'b1;
        if (cnt_q <= CntW'(1)) state_d = StIdle;
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase

    // Reset masks every control output; forwarding stays live.
    if (rst) begin
      stall_all = 1'b0;
      stall_fd  = 1'b0;
      flush_fd  = 1'b0;
      flush_de  = 1'b0;
      start     = 1'b0;
      busy      = 1'b0;
      flush_evt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.stall_fetch && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.forward_sel       = fwd;
  assign bus.stall_fetch       = stall_all | stall_fd;
  assign bus.stall_dec         = stall_all | stall_fd;
  assign bus.stall_ex          = stall_all;
  assign bus.flush_fetch_dec   = flush_fd;
  assign bus.flush_dec_ex      = flush_de;
  assign bus.mc_start          = start;
  assign bus.mc_busy           = busy;
  assign bus.perf_stall_cycles = stall_cnt_q;
  assign bus.perf_flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: two configurations driven by shared stimulus and
// checked every cycle against a cycle-count based reference model.
module tb_hazard_ctrl_mc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [14:0] ex_rs, dec_rs;
  logic [4:0]  ex_rd, mem_wa, wb_wa;
  logic [2:0]  dec_used;
  logic        ex_valid, ex_mem_read, ex_mc_op, mem_we, wb_we, take_branch, mc_done;

  hazard_ctrl_mc_if #(.REG_ADDR_W(5), .NUM_SRC(3), .CNT_W(32)) if_h ();
  hazard_ctrl_mc_if #(.REG_ADDR_W(5), .NUM_SRC(3), .CNT_W(2))  if_f ();

  hazard_ctrl_mc #(
    .REG_ADDR_W(5), .NUM_SRC(3), .MC_FIXED_LATENCY(0), .FLUSH_DEPTH(2), .CNT_W(32)
  ) dut_h (.clk(clk), .rst(rst), .bus(if_h));

  hazard_ctrl_mc #(
    .REG_ADDR_W(5), .NUM_SRC(3), .MC_FIXED_LATENCY(3), .FLUSH_DEPTH(3), .CNT_W(2)
  ) dut_f (.clk(clk), .rst(rst), .bus(if_f));

  assign if_h.ex_rs_addr = ex_rs;            assign if_f.ex_rs_addr = ex_rs;
  assign if_h.ex_rd_addr = ex_rd;            assign if_f.ex_rd_addr = ex_rd;
  assign if_h.ex_valid = ex_valid;           assign if_f.ex_valid = ex_valid;
  assign if_h.ex_mem_read = ex_mem_read;     assign if_f.ex_mem_read = ex_mem_read;
  assign if_h.ex_mc_op = ex_mc_op;           assign if_f.ex_mc_op = ex_mc_op;
  assign if_h.dec_rs_addr = dec_rs;          assign if_f.dec_rs_addr = dec_rs;
  assign if_h.dec_rs_used = dec_used;        assign if_f.dec_rs_used = dec_used;
  assign if_h.mem_reg_write_addr = mem_wa;   assign if_f.mem_reg_write_addr = mem_wa;
  assign if_h.mem_reg_write_signal = mem_we; assign if_f.mem_reg_write_signal = mem_we;
  assign if_h.wb_reg_write_addr = wb_wa;     assign if_f.wb_reg_write_addr = wb_wa;
  assign if_h.wb_reg_write_signal = wb_we;   assign if_f.wb_reg_write_signal = wb_we;
  assign if_h.take_branch = take_branch;     assign if_f.take_branch = take_branch;
  assign if_h.mc_done = mc_done;             assign if_f.mc_done = mc_done;

  // {stall_fetch, stall_dec, stall_ex, flush_fetch_dec, flush_dec_ex, mc_start, mc_busy}
  logic [6:0]  ctl [2];
  logic [5:0]  fs  [2];
  logic [31:0] pst [2];
  logic [31:0] pfl [2];

  assign ctl[0] = {if_h.stall_fetch, if_h.stall_dec, if_h.stall_ex, if_h.flush_fetch_dec,
                   if_h.flush_dec_ex, if_h.mc_start, if_h.mc_busy};
  assign ctl[1] = {if_f.stall_fetch, if_f.stall_dec, if_f.stall_ex, if_f.flush_fetch_dec,
                   if_f.flush_dec_ex, if_f.mc_start, if_f.mc_busy};
  assign fs[0]  = if_h.forward_sel;
  assign fs[1]  = if_f.forward_sel;
  assign pst[0] = if_h.perf_stall_cycles;
  assign pst[1] = {30'd0, if_f.perf_stall_cycles};
  assign pfl[0] = if_h.perf_flush_count;
  assign pfl[1] = {30'd0, if_f.perf_flush_count};

  // Per-instance configuration and model state.
  int     lat  [2] = '{0, 3};
  int     fdep [2] = '{2, 3};
  longint cmax [2] = '{64'hFFFF_FFFF, 3};
  bit     mc_act  [2];
  int     mc_stalls [2];   // stall cycles already spent on the current op
  int     fl_cnt  [2];     // flush cycles already asserted for current branch (0 = none)
  longint st_cnt  [2];
  longint fl_perf [2];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] fwd_model();
    logic [5:0] r;
    logic [4:0] s;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      s = ex_rs[i*5 +: 5];
      if (s != 0 && mem_we && s == mem_wa)     r[2*i +: 2] = 2'b11;
      else if (s != 0 && wb_we && s == wb_wa)  r[2*i +: 2] = 2'b10;
    end
    return r;
  endfunction

  function automatic bit lu_model();
    bit hit;
    hit = 0;
    for (int i = 0; i < 3; i++) begin
      if (dec_used[i] && dec_rs[i*5 +: 5] == ex_rd) hit = 1;
    end
    return hit && ex_valid && ex_mem_read && ex_rd != 0;
  endfunction

  task automatic eval();
    logic [5:0] efwd;
    bit lu, sf, sd, se, ffd, fde, st, bz, done, fev;
    @(negedge clk);
    efwd = fwd_model();
    lu   = lu_model();
    for (int k = 0; k < 2; k++) begin
      {sf, sd, se, ffd, fde, st, bz, fev} = '0;
      if (!rst) begin
        if (mc_act[k]) begin
          bz   = 1;
          done = (lat[k] == 0) ? mc_done : (mc_stalls[k] >= lat[k]);
          if (done) mc_act[k] = 0;
          else begin {sf, sd, se} = 3'b111; mc_stalls[k]++; end
        end else if (fl_cnt[k] != 0) begin
          ffd = 1;
          fl_cnt[k]++;
          if (fl_cnt[k] >= fdep[k]) fl_cnt[k] = 0;
        end else if (ex_valid && ex_mc_op) begin
          {sf, sd, se, st} = 4'b1111;
          mc_act[k]    = 1;
          mc_stalls[k] = 1;
        end else if (take_branch) begin
          ffd = 1; fde = 1; fev = 1;
          fl_cnt[k] = (fdep[k] > 1) ? 1 : 0;
        end else if (lu) begin
          sf = 1; sd = 1; fde = 1;
        end
      end
      check_eq($sformatf("fwd%0d", k), fs[k], efwd);
      check_eq($sformatf("ctl%0d", k), ctl[k], {sf, sd, se, ffd, fde, st, bz});
      check_eq($sformatf("pst%0d", k), pst[k], st_cnt[k]);
      check_eq($sformatf("pfl%0d", k), pfl[k], fl_perf[k]);
      if (rst) begin
        mc_act[k] = 0; fl_cnt[k] = 0; st_cnt[k] = 0; fl_perf[k] = 0;
      end else begin
        if (sf && st_cnt[k] < cmax[k]) st_cnt[k]++;
        if (fev && fl_perf[k] < cmax[k]) fl_perf[k]++;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; ex_rs = '0; dec_rs = '0; ex_rd = '0; mem_wa = '0; wb_wa = '0; dec_used = '0;
    ex_valid = 0; ex_mem_read = 0; ex_mc_op = 0; mem_we = 0; wb_we = 0;
    take_branch = 0; mc_done = 0;
  endtask

  task automatic reset_pulse();
    rst = 1; eval(); adv(); rst = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    adv();
    rst = 1; eval(); adv();
    clear_inputs();
    eval();
    check_eq("rst_ctl", ctl[0], 7'd0);
    check_eq("rst_pst", pst[0], 32'd0);
    adv();

    // Forwarding priority and x0 exclusion.
    ex_rs = {5'd0, 5'd5, 5'd5}; mem_wa = 5'd5; mem_we = 1; wb_wa = 5'd5; wb_we = 1;
    eval(); check_eq("fwd_mem", fs[0], 6'b001111); adv();
    mem_we = 0;
    eval(); check_eq("fwd_wb", fs[0], 6'b001010); adv();
    ex_rs = '0; mem_wa = '0; mem_we = 1; wb_wa = '0;
    eval(); check_eq("fwd_x0", fs[0], 6'b000000); adv();

    // Load-use stall, then unused source.
    clear_inputs();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd7; dec_rs = {5'd0, 5'd0, 5'd7}; dec_used = 3'b001;
    eval(); check_eq("lu_ctl", ctl[0], 7'b1100100); adv();
    dec_used = 3'b000;
    eval(); check_eq("lu_unused", ctl[0], 7'd0); check_eq("lu_pst", pst[0], 32'd1); adv();

    // Multicycle handshake: done arrives at cycle 4.
    clear_inputs(); reset_pulse();
    for (int c = 0; c < 6; c++) begin
      ex_valid = 1; ex_mc_op = (c < 5); mc_done = (c == 4);
      eval();
      if (c == 0) check_eq("mc_c0", ctl[0], 7'b1110010);
      if (c == 2) check_eq("mc_c2", ctl[0], 7'b1110001);
      if (c == 4) check_eq("mc_c4", ctl[0], 7'b0000001);
      if (c == 5) check_eq("mc_pst", pst[0], 32'd4);
      adv();
    end

    // Branch coincident with load-use.
    clear_inputs(); reset_pulse();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd7; dec_rs = {5'd0, 5'd0, 5'd7}; dec_used = 3'b001;
    take_branch = 1;
    eval(); check_eq("br_c0", ctl[0], 7'b0001100); adv();
    take_branch = 0; ex_valid = 0;
    eval(); check_eq("br_c1", ctl[0], 7'b0001000); adv();
    eval(); check_eq("br_cnt", pfl[0], 32'd1); check_eq("br_pst", pst[0], 32'd0); adv();

    // Reset in the middle of MC_WAIT.
    clear_inputs();
    ex_valid = 1; ex_mc_op = 1;
    for (int c = 0; c < 3; c++) begin eval(); adv(); end
    rst = 1; eval(); adv(); rst = 0; ex_mc_op = 0; ex_valid = 0;
    eval();
    check_eq("rst_mc_ctl", ctl[0], 7'd0);
    check_eq("rst_mc_pst", pst[0], 32'd0);
    check_eq("rst_mc_pfl", pfl[0], 32'd0);
    adv();

    // Five branches into a 2-bit counter.
    take_branch = 1;
    for (int c = 0; c < 15; c++) begin eval(); adv(); end
    take_branch = 0;
    eval(); check_eq("sat_pfl", pfl[1], 32'd3); adv();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rst         = ($urandom_range(0, 39) == 0);
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_mc_op    = ($urandom_range(0, 7) == 0);
      take_branch = ($urandom_range(0, 5) == 0);
      mc_done     = ($urandom_range(0, 2) == 0);
      mem_we      = $urandom_range(0, 1);
      wb_we       = $urandom_range(0, 1);
      dec_used    = 3'($urandom_range(0, 7));
      ex_rd       = 5'($urandom_range(0, 3));
      mem_wa      = 5'($urandom_range(0, 3));
      wb_wa       = 5'($urandom_range(0, 3));
      for (int i = 0; i < 3; i++) begin
        ex_rs[i*5 +: 5]  = 5'($urandom_range(0, 3));
        dec_rs[i*5 +: 5] = 5'($urandom_range(0, 3));
      end
      eval();
      adv();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
